// File: rtl/csr_pkg.sv
// Shared register map, ID word and pop FSM state type for the APB CSR bank.
package csr_pkg;

    localparam logic [31:0] CTRL_BASE     = 32'h000;
    localparam logic [31:0] STAT_BASE     = 32'h100;
    localparam logic [31:0] PULSE_OFS     = 32'h200;
    localparam logic [31:0] FIFO_DATA_OFS = 32'h204;
    localparam logic [31:0] FIFO_STAT_OFS = 32'h208;
    localparam logic [31:0] IRQ_PEND_OFS  = 32'h20C;
    localparam logic [31:0] IRQ_MASK_OFS  = 32'h210;
    localparam logic [31:0] ID_OFS        = 32'h214;

    localparam logic [31:0] CSR_ID = 32'h5242_0002;

    typedef enum logic [1:0] {IDLE, POP, CAPT} csr_st_t;

endpackage

// File: rtl/apb_fifo_pop.sv
// FIFO pop sequencer: issues one fifo_rd_en, captures the returned word, then
// presents it for a single completing cycle (two APB wait states in total).
module apb_fifo_pop
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] fifo_rd_data,
    output logic        fifo_rd_en,
    output logic        pop_ready,
    output logic [31:0] pop_data,
    output logic        busy
);

    csr_st_t     st_q, st_d;
    logic [31:0] cap_q, cap_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q  <= IDLE;
            cap_q <= '0;
        end else begin
            st_q  <= st_d;
            cap_q <= cap_d;
        end
    end

    always_comb begin
        st_d       = st_q;
        cap_d      = cap_q;
        fifo_rd_en = 1'b0;
        pop_ready  = 1'b0;
        pop_data   = '0;
        busy       = (st_q != IDLE);
        unique case (st_q)
            IDLE: begin
                if (start) begin
                    fifo_rd_en = 1'b1;
                    st_d       = POP;
                end
            end
            POP: begin
                // Upstream data is valid the cycle after fifo_rd_en.
                cap_d = fifo_rd_data;
                st_d  = CAPT;
            end
            CAPT: begin
                pop_ready = 1'b1;
                pop_data  = cap_q;
                st_d      = IDLE;
            end
            default: st_d = IDLE;
        endcase
    end

endmodule

// File: rtl/apb_csr_bank.sv
// APB3 control/status register bank with FIFO push/pop window.
// Optional interrupt pend/mask registers are built when CSR_IRQ_EN is defined.
module apb_csr_bank
    import csr_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 12,
    parameter int unsigned         N_CTRL   = 8,
    parameter int unsigned         N_STAT   = 4,
    parameter int unsigned         N_PULSE  = 8,
    parameter int unsigned         N_IRQ    = 4,
    parameter logic [N_CTRL*32-1:0] CTRL_RST = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_W-1:0]      paddr,
    input  logic [31:0]            pwdata,
    input  logic [3:0]             pstrb,
    output logic [31:0]            prdata,
    output logic                   pready,
    output logic                   pslverr,
    output logic [N_CTRL*32-1:0]   ctrl_q,
    output logic [N_CTRL-1:0]      ctrl_wr_stb,
    input  logic [N_STAT*32-1:0]   stat_d,
    output logic [N_PULSE-1:0]     pulse,
    output logic [31:0]            fifo_wr_data,
    output logic                   fifo_wr_en,
    input  logic                   fifo_wr_full,
    input  logic [31:0]            fifo_rd_data,
    output logic                   fifo_rd_en,
    input  logic                   fifo_rd_empty,
    input  logic [N_IRQ-1:0]       irq_src,
    output logic                   irq
);

    logic [31:0] ofs;
    logic [5:0]  idx;
    logic ctrl_hit, stat_hit, pulse_hit, fdata_hit, fstat_hit, pend_hit, mask_hit, id_hit;
    logic mapped, ro_hit, err, acc, pop_start, wr_ok, busy, pop_ready;
    logic [31:0] pop_data, rd_word;

    logic [N_CTRL*32-1:0] ctrl_d;
    logic [N_CTRL-1:0]    ctrl_wr_stb_q, ctrl_wr_stb_d;
    logic [N_PULSE-1:0]   pulse_q, pulse_d;
    logic [31:0]          fifo_wr_data_q, fifo_wr_data_d;
    logic                 fifo_wr_en_q, fifo_wr_en_d;

    assign ofs = 32'({paddr[ADDR_W-1:2], 2'b00});
    assign idx = ofs[7:2];

    // Unsigned wrap makes the subtract-and-compare a single range check.
    assign ctrl_hit  = (ofs - CTRL_BASE) < 32'(4 * N_CTRL);
    assign stat_hit  = (ofs - STAT_BASE) < 32'(4 * N_STAT);
    assign pulse_hit = (ofs == PULSE_OFS);
    assign fdata_hit = (ofs == FIFO_DATA_OFS);
    assign fstat_hit = (ofs == FIFO_STAT_OFS);
    assign id_hit    = (ofs == ID_OFS);

    assign mapped = ctrl_hit | stat_hit | pulse_hit | fdata_hit | fstat_hit | pend_hit |
                    mask_hit | id_hit;
    assign ro_hit = stat_hit | fstat_hit | id_hit;
    assign err    = ~mapped | (pwrite & ro_hit) | (fdata_hit & pwrite & fifo_wr_full) |
                    (fdata_hit & ~pwrite & fifo_rd_empty);

    // Gating with reset_n keeps every APB output low while reset is held.
    assign acc       = reset_n & psel & penable & ~busy;
    assign pop_start = acc & ~pwrite & fdata_hit & ~fifo_rd_empty;
    assign wr_ok     = acc & pwrite & ~err;

    apb_fifo_pop u_pop (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (pop_start),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .pop_ready    (pop_ready),
        .pop_data     (pop_data),
        .busy         (busy)
    );

    assign pready  = (acc & ~pop_start) | pop_ready;
    assign pslverr = acc & err;
    assign prdata  = pop_ready ? pop_data :
                     (acc & ~pwrite & ~err & ~pop_start) ? rd_word : '0;

`ifdef CSR_IRQ_EN
    logic [N_IRQ-1:0] irq_pend_q, irq_pend_d, irq_mask_q, irq_mask_d;
    logic             irq_q, irq_d;

    assign pend_hit = (ofs == IRQ_PEND_OFS);
    assign mask_hit = (ofs == IRQ_MASK_OFS);

    always_comb begin
        irq_pend_d = irq_pend_q;
        irq_mask_d = irq_mask_q;
        if (wr_ok && pend_hit) begin
            irq_pend_d = irq_pend_q & ~pwdata[N_IRQ-1:0];
        end
        // A source still high re-sets its bit even on the clearing cycle.
        irq_pend_d = irq_pend_d | irq_src;
        if (wr_ok && mask_hit) begin
            irq_mask_d = pwdata[N_IRQ-1:0];
        end
        irq_d = |(irq_pend_q & irq_mask_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pend_q <= '0;
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_pend_q <= irq_pend_d;
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_src;

    assign pend_hit       = 1'b0;
    assign mask_hit       = 1'b0;
    assign irq            = 1'b0;
    assign unused_irq_src = ^irq_src;
`endif

    logic unused_paddr;
    assign unused_paddr = ^paddr[1:0];

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < int'(N_CTRL); i++) begin
            if (ctrl_hit && idx == 6'(i)) rd_word = ctrl_q[32*i +: 32];
        end
        for (int i = 0; i < int'(N_STAT); i++) begin
            if (stat_hit && idx == 6'(i)) rd_word = stat_d[32*i +: 32];
        end
        if (fstat_hit) rd_word = {30'd0, fifo_rd_empty, fifo_wr_full};
        if (id_hit)    rd_word = CSR_ID;
`ifdef CSR_IRQ_EN
        if (pend_hit)  rd_word = 32'(irq_pend_q);
        if (mask_hit)  rd_word = 32'(irq_mask_q);
`endif
    end

    always_comb begin
        ctrl_d        = ctrl_q;
        ctrl_wr_stb_d = '0;
        for (int i = 0; i < int'(N_CTRL); i++) begin
            if (wr_ok && ctrl_hit && idx == 6'(i)) begin
                ctrl_wr_stb_d[i] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (pstrb[b]) ctrl_d[32*i+8*b +: 8] = pwdata[8*b +: 8];
                end
            end
        end
        pulse_d        = (wr_ok && pulse_hit) ? pwdata[N_PULSE-1:0] : '0;
        fifo_wr_en_d   = wr_ok & fdata_hit;
        fifo_wr_data_d = fifo_wr_en_d ? pwdata : fifo_wr_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q         <= CTRL_RST;
            ctrl_wr_stb_q  <= '0;
            pulse_q        <= '0;
            fifo_wr_data_q <= '0;
            fifo_wr_en_q   <= 1'b0;
        end else begin
            ctrl_q         <= ctrl_d;
            ctrl_wr_stb_q  <= ctrl_wr_stb_d;
            pulse_q        <= pulse_d;
            fifo_wr_data_q <= fifo_wr_data_d;
            fifo_wr_en_q   <= fifo_wr_en_d;
        end
    end

    assign ctrl_wr_stb  = ctrl_wr_stb_q;
    assign pulse        = pulse_q;
    assign fifo_wr_data = fifo_wr_data_q;
    assign fifo_wr_en   = fifo_wr_en_q;

endmodule

// File: tb/tb_apb_csr_bank.sv
// Scoreboard bench for apb_csr_bank: stimulus pushes model predictions, a monitor checks them.
`timescale 1ns/1ps
module tb_apb_csr_bank;

    localparam int N_CTRL  = 8;
    localparam int N_STAT  = 4;
    localparam int N_PULSE = 8;
    localparam int N_IRQ   = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  psel, penable, pwrite;
    logic [11:0]           paddr;
    logic [31:0]           pwdata;
    logic [3:0]            pstrb;
    logic [31:0]           prdata;
    logic                  pready, pslverr;
    logic [N_CTRL*32-1:0]  ctrl_q;
    logic [N_CTRL-1:0]     ctrl_wr_stb;
    logic [N_STAT*32-1:0]  stat_d;
    logic [N_PULSE-1:0]    pulse;
    logic [31:0]           fifo_wr_data;
    logic                  fifo_wr_en, fifo_wr_full;
    logic [31:0]           fifo_rd_data;
    logic                  fifo_rd_en, fifo_rd_empty;
    logic [N_IRQ-1:0]      irq_src;
    logic                  irq;

    always #5 clk = ~clk;

    apb_csr_bank #(
        .ADDR_W   (12),
        .N_CTRL   (N_CTRL),
        .N_STAT   (N_STAT),
        .N_PULSE  (N_PULSE),
        .N_IRQ    (N_IRQ),
        .CTRL_RST ('0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .psel          (psel),
        .penable       (penable),
        .pwrite        (pwrite),
        .paddr         (paddr),
        .pwdata        (pwdata),
        .pstrb         (pstrb),
        .prdata        (prdata),
        .pready        (pready),
        .pslverr       (pslverr),
        .ctrl_q        (ctrl_q),
        .ctrl_wr_stb   (ctrl_wr_stb),
        .stat_d        (stat_d),
        .pulse         (pulse),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_full  (fifo_wr_full),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_empty (fifo_rd_empty),
        .irq_src       (irq_src),
        .irq           (irq)
    );

    typedef struct {
        logic [31:0]          rdata;
        logic                 err;
        int                   waits;
        int                   rd_ens;
        logic [N_CTRL-1:0]    stb;
        logic [N_PULSE-1:0]   pulse;
        logic                 wr_en;
        logic [31:0]          wr_data;
        logic [N_CTRL*32-1:0] ctrl;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_ctrl [N_CTRL];
    logic [N_IRQ-1:0] m_pend, m_mask;
    logic [31:0] up_next;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic chk_ctrl(input logic [N_CTRL*32-1:0] act, input logic [N_CTRL*32-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL ctrl_q: got %0h required %0h", act, req);
        end
    endtask

    // Upstream FIFO: word appears the cycle after a pop, garbage otherwise.
    always @(posedge clk) fifo_rd_data <= fifo_rd_en ? up_next : ~up_next;

    // Reference model: register map semantics, evaluated when a transfer is issued.
    function automatic exp_t model(input bit wr, input logic [11:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
        exp_t        e = '{default: '0};
        int unsigned o = {20'd0, a[11:2], 2'b00};
        if (o < 4 * N_CTRL) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) if (s[b]) m_ctrl[o/4][8*b +: 8] = d[8*b +: 8];
                e.stb[o/4] = 1'b1;
            end else e.rdata = m_ctrl[o/4];
        end else if (o >= 'h100 && o < 'h100 + 4 * N_STAT) begin
            if (wr) e.err = 1'b1;
            else e.rdata = stat_d[32*((o - 'h100)/4) +: 32];
        end else begin
            case (o)
                'h200: if (wr) e.pulse = d[N_PULSE-1:0];
                'h204: begin
                    if (wr) begin
                        if (fifo_wr_full) e.err = 1'b1;
                        else begin e.wr_en = 1'b1; e.wr_data = d; end
                    end else if (fifo_rd_empty) e.err = 1'b1;
                    else begin e.rdata = up_next; e.waits = 2; e.rd_ens = 1; end
                end
                'h208: if (wr) e.err = 1'b1; else e.rdata = {30'd0, fifo_rd_empty, fifo_wr_full};
`ifdef CSR_IRQ_EN
                'h20C: if (wr) m_pend = (m_pend & ~d[N_IRQ-1:0]) | irq_src;
                       else e.rdata = 32'(m_pend);
                'h210: if (wr) m_mask = d[N_IRQ-1:0]; else e.rdata = 32'(m_mask);
`endif
                'h214: if (wr) e.err = 1'b1; else e.rdata = 32'h5242_0002;
                default: e.err = 1'b1;
            endcase
        end
        for (int i = 0; i < N_CTRL; i++) e.ctrl[32*i +: 32] = m_ctrl[i];
        return e;
    endfunction

    task automatic apb(input bit wr, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        int n = 0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        exp_q.push_back(model(wr, a, d, s));
        @(posedge clk); #1 penable = 1'b1;
        forever begin
            @(negedge clk);
            if (pready) break;
            n++;
            if (n > 6) begin
                checks++; failures++;
                $display("FAIL apb_timeout addr=%0h: got no pready required pready", a);
                exp_q.delete();
                break;
            end
        end
        @(posedge clk); #1 psel = 1'b0; penable = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_CTRL; i++) m_ctrl[i] = '0;
        m_pend = '0;
        m_mask = '0;
    endtask

    // Monitor: response checks at completion, side-effect checks one cycle later.
    int   mon_waits = 0;
    int   mon_rdens = 0;
    bit   mon_post  = 1'b0;
    exp_t cur;

    always @(negedge clk) begin
        if (!reset_n) begin
            mon_waits = 0; mon_rdens = 0; mon_post = 1'b0;
        end else begin
            if (mon_post) begin
                chk_ctrl(ctrl_q, cur.ctrl);
                chk("ctrl_wr_stb", 64'(ctrl_wr_stb), 64'(cur.stb));
                chk("pulse", 64'(pulse), 64'(cur.pulse));
                chk("fifo_wr_en", 64'(fifo_wr_en), 64'(cur.wr_en));
                if (cur.wr_en) chk("fifo_wr_data", 64'(fifo_wr_data), 64'(cur.wr_data));
                mon_post = 1'b0;
            end else begin
                chk("strobes_quiet", 64'({ctrl_wr_stb, pulse, fifo_wr_en}), 64'(0));
            end
            if (psel && penable) begin
                if (fifo_rd_en) mon_rdens++;
                if (pready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_completion: got pready required no transfer");
                    end else begin
                        cur = exp_q.pop_front();
                        chk("prdata", 64'(prdata), 64'(cur.rdata));
                        chk("pslverr", 64'(pslverr), 64'(cur.err));
                        chk("wait_states", 64'(mon_waits), 64'(cur.waits));
                        chk("fifo_rd_en_count", 64'(mon_rdens), 64'(cur.rd_ens));
                        mon_post = 1'b1;
                    end
                    mon_waits = 0; mon_rdens = 0;
                end else mon_waits++;
            end else begin
                chk("fifo_rd_en_idle", 64'(fifo_rd_en), 64'(0));
            end
        end
    end

    initial begin
        logic [11:0] a;
        int          sel;
        reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; stat_d = '0; fifo_wr_full = 1'b0; fifo_rd_empty = 1'b1;
        irq_src = '0; up_next = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_ctrl(ctrl_q, '0);
        chk("rst_outputs", 64'({prdata, pready, pslverr, fifo_rd_en, fifo_wr_en, irq}), 64'(0));
        chk("rst_strobes", 64'({ctrl_wr_stb, pulse}), 64'(0));
        @(posedge clk); #1 reset_n = 1'b1;

        // Byte-strobed control write.
        apb(1'b1, 12'h00C, 32'hDEAD_BEEF, 4'b0101);
        chk("ctrl3_strobed", 64'(ctrl_q[127:96]), 64'h00AD_00EF);
        apb(1'b0, 12'h00C, 32'h0, 4'h0);

        // Pop with data, pop when empty.
        fifo_rd_empty = 1'b0; up_next = 32'h0000_1234;
        apb(1'b0, 12'h204, 32'h0, 4'h0);
        fifo_rd_empty = 1'b1;
        apb(1'b0, 12'h204, 32'h0, 4'h0);

        // Push blocked by full, then accepted.
        fifo_wr_full = 1'b1;
        apb(1'b1, 12'h204, 32'h0000_00A5, 4'hF);
        fifo_wr_full = 1'b0;
        apb(1'b1, 12'h204, 32'h0000_00A5, 4'hF);

        // Pulse, unmapped read, out-of-range status index.
        apb(1'b1, 12'h200, 32'h0000_0081, 4'hF);
        apb(1'b0, 12'h3FC, 32'h0, 4'h0);
        apb(1'b0, 12'(32'h100 + 4 * N_STAT), 32'h0, 4'h0);
        apb(1'b0, 12'h214, 32'h0, 4'h0);

`ifdef CSR_IRQ_EN
        apb(1'b1, 12'h210, 32'h4, 4'hF);
        @(posedge clk); #1 irq_src = 4'b0100; m_pend = m_pend | 4'b0100;
        repeat (3) @(posedge clk);
        @(negedge clk); chk("irq_set", 64'(irq), 64'(1));
        apb(1'b1, 12'h20C, 32'h4, 4'hF);
        apb(1'b0, 12'h20C, 32'h0, 4'h0);
        @(negedge clk); chk("irq_held", 64'(irq), 64'(1));
        @(posedge clk); #1 irq_src = '0;
        apb(1'b1, 12'h20C, 32'h4, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk); chk("irq_cleared", 64'(irq), 64'(0));
`else
        apb(1'b0, 12'h20C, 32'h0, 4'h0);
        apb(1'b1, 12'h210, 32'hF, 4'hF);
        irq_src = '1;
        repeat (3) @(posedge clk);
        @(negedge clk); chk("irq_tied_low", 64'(irq), 64'(0));
        irq_src = '0;
`endif

        for (int it = 0; it < 300; it++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    a = 12'(4 * $urandom_range(0, N_CTRL + 1));
                2:       a = 12'(32'h100 + 4 * $urandom_range(0, N_STAT));
                3:       a = 12'h200;
                4, 5:    a = 12'h204;
                6:       a = 12'h208;
                7:       a = ($urandom_range(0, 1) == 1) ? 12'h20C : 12'h210;
                8:       a = 12'h214;
                default: a = 12'($urandom);
            endcase
            a = a | 12'($urandom_range(0, 3));
            stat_d = {$urandom, $urandom, $urandom, $urandom};
            fifo_wr_full = 1'($urandom_range(0, 1));
            fifo_rd_empty = 1'($urandom_range(0, 1));
            up_next = $urandom;
            apb(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom));
        end

        // Reset in the middle of a pop.
        fifo_rd_empty = 1'b0; fifo_wr_full = 1'b0; up_next = 32'hCAFE_0001;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h204;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 reset_n = 1'b0;
        #1;
        model_reset();
        chk_ctrl(ctrl_q, '0);
        chk("rst_pop_outputs", 64'({prdata, pready, pslverr, fifo_rd_en, fifo_wr_en, irq}), 64'(0));
        chk("rst_pop_strobes", 64'({ctrl_wr_stb, pulse}), 64'(0));
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        up_next = 32'h0BAD_F00D;
        apb(1'b0, 12'h204, 32'h0, 4'h0);
        apb(1'b0, 12'h000, 32'h0, 4'h0);

        repeat (3) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
